io_axil_responder: RTL and testbench
====================================

IO_AXIL_RESPONDER -- requirements
Module: io_axil_responder

Interface
REQ-001 Parameter DEPTH, default 8, entries per FIFO; power of two, at least 2.
REQ-002 CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 RST  in  1  synchronous, active-high reset.
REQ-004 S_AXI_AWADDR  in  4  write address, byte offset.
REQ-005 S_AXI_AWVALID  in  1  write address valid.
REQ-006 S_AXI_AWREADY  out  1  write address accepted.
REQ-007 S_AXI_WDATA  in  32  write data; bits [7:0] used.
REQ-008 S_AXI_WSTB  in  4  byte strobes; ignored.
REQ-009 S_AXI_WVALID  in  1  write data valid.
REQ-010 S_AXI_WREADY  out  1  write data accepted.
REQ-011 S_AXI_BRESP  out  2  write response.
REQ-012 S_AXI_BVALID  out  1  write response valid.
REQ-013 S_AXI_BREADY  in  1  write response taken.
REQ-014 S_AXI_ARADDR  in  4  read address, byte offset.
REQ-015 S_AXI_ARVALID  in  1  read address valid.
REQ-016 S_AXI_ARREADY  out  1  read address accepted.
REQ-017 S_AXI_RDATA  out  32  read data.
REQ-018 S_AXI_RRESP  out  2  read response.
REQ-019 S_AXI_RVALID  out  1  read data valid.
REQ-020 S_AXI_RREADY  in  1  read data taken.
REQ-021 IN_DATA  in  8  byte from external input source.
REQ-022 IN_VALID  in  1  IN_DATA valid.
REQ-023 IN_READY  out  1  RX FIFO not full.
REQ-024 OUT_DATA  out  8  byte to external sink.
REQ-025 OUT_VALID  out  1  TX FIFO not empty.
REQ-026 OUT_READY  in  1  sink accepts OUT_DATA.

Function
REQ-027 Register map: 0x0 RX_DATA (RO, read pops RX FIFO), 0x4 TX_DATA (WO, write pushes WDATA[7:0]), 0x8 STATUS (RO: bit0 RX non-empty, bit1 TX full, bit2 TX empty, rest 0), 0xC reserved; ADDR[1:0] ignored.
REQ-028 RX FIFO push when IN_VALID&IN_READY; TX FIFO pop when OUT_VALID&OUT_READY; OUT_DATA = TX head, combinational from FIFO storage.
REQ-029 Write path: AW and W accepted independently, each latched once, READY deasserted while its latch is full; AWREADY=~aw_held, WREADY=~w_held.
REQ-030 Write executes the cycle both latches are full and BVALID is low; BVALID rises next cycle; latches clear on execution; BVALID holds until BREADY, then falls.
REQ-031 AW and W in the same cycle: both latched; BVALID high 2 cycles after handshake.
REQ-032 Read path: ARREADY = ~RVALID; on AR handshake RDATA/RRESP register and RVALID rises next cycle, held stable until RREADY.
REQ-033 BRESP/RRESP: OKAY=2'b00; SLVERR=2'b10 for write to 0x0/0x8/0xC, TX_DATA write when TX full (byte dropped), RX_DATA read when RX empty (RDATA=0, no pop), read of 0x4/0xC (RDATA=0).
REQ-034 RX_DATA read returns {24'b0, head} and pops at the AR handshake cycle; STATUS reflects FIFO state at the AR handshake cycle.
REQ-035 Simultaneous push and pop on a full FIFO: pop succeeds, push blocked only if full before the pop (IN_READY, TX-full are registered-state based); on empty FIFO, pop not performed.
REQ-036 FIFO pointers are log2(DEPTH)+1 bits, wrap modulo 2*DEPTH; full = MSBs differ and low bits equal.

Reset
REQ-037 RST high: all READY, BVALID, RVALID, OUT_VALID low except IN_READY=1 and AWREADY=WREADY=ARREADY=1 on the first cycle after reset; BRESP=RRESP=0, RDATA=0, both FIFOs empty, latches cleared.
REQ-038 RST mid-transaction discards pending AW/W/AR and FIFO contents; no response issued afterwards.

Structure
REQ-039 Shared package io_pkg holds register offsets, RESP_OKAY/RESP_SLVERR, STATUS bit indices.
REQ-040 One sub-module io_fifo (parameterised width/DEPTH, push/pop/full/empty/head), instantiated for RX and TX.

Verification
REQ-041 W then AW two cycles later to 0x4, data 0x41 -> one BVALID with BRESP=00, OUT_DATA=0x41, OUT_VALID=1.
REQ-042 IN_DATA 0x5A pushed, AR 0x0 -> RDATA=0x5A, RRESP=00; next AR 0x0 -> RDATA=0, RRESP=10.
REQ-043 DEPTH+1 TX writes, OUT_READY=0 -> first DEPTH OKAY, last SLVERR, STATUS read = 0x2.
REQ-044 BREADY held low 5 cycles -> BVALID stays high, AWREADY/WREADY stay low after second latch fills, no second write executed.
REQ-045 Full RX, IN_VALID and RX_DATA pop same cycle -> IN_READY=0 that cycle, pop returns oldest byte, next cycle IN_READY=1.
REQ-046 RST asserted with AW latched and RVALID high -> all valids low next cycle, no BVALID afterwards.

Source files
------------

// File: rtl/io_pkg.sv
// io_pkg: register map, response codes and STATUS layout shared by the AXI-Lite byte I/O responder.
package io_pkg;
  localparam logic [3:0] ADDR_RX_DATA = 4'h0;
  localparam logic [3:0] ADDR_TX_DATA = 4'h4;
  localparam logic [3:0] ADDR_STATUS  = 4'h8;
  localparam logic [3:0] ADDR_RSVD    = 4'hC;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int STAT_RX_NE    = 0;
  localparam int STAT_TX_FULL  = 1;
  localparam int STAT_TX_EMPTY = 2;
  typedef enum logic [1:0] {
    REG_RX     = ADDR_RX_DATA[3:2],
    REG_TX     = ADDR_TX_DATA[3:2],
    REG_STATUS = ADDR_STATUS[3:2],
    REG_RSVD   = ADDR_RSVD[3:2]
  } reg_e;
  function automatic logic [31:0] status_word(input logic rx_empty, input logic tx_full, input logic tx_empty);
    logic [31:0] s;
    s = '0;
    s[STAT_RX_NE] = ~rx_empty;
    s[STAT_TX_FULL] = tx_full;
    s[STAT_TX_EMPTY] = tx_empty;
    return s;
  endfunction
endpackage

// File: rtl/io_fifo.sv
// io_fifo: synchronous FIFO with wrap-bit pointers; push/pop are ignored when full/empty.
module io_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp, rp;
  logic [W-1:0] mem [DEPTH];
  logic do_push, do_pop;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign head = mem[rp[AW-1:0]];
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/io_axil_responder.sv
// io_axil_responder: AXI4-Lite slave bridging a byte-wide RX source and TX sink through two FIFOs.
module io_axil_responder
  import io_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  S_AXI_AWADDR,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [31:0] S_AXI_WDATA,
  input  logic [3:0]  S_AXI_WSTB,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic [1:0]  S_AXI_BRESP,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  input  logic [3:0]  S_AXI_ARADDR,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic [31:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY,
  input  logic [7:0]  IN_DATA,
  input  logic        IN_VALID,
  output logic        IN_READY,
  output logic [7:0]  OUT_DATA,
  output logic        OUT_VALID,
  input  logic        OUT_READY
);
  logic aw_held, w_held, bvalid, rvalid;
  reg_e aw_sel, ar_sel;
  logic [7:0] w_byte, rx_head, tx_head;
  logic [1:0] bresp, rresp, wr_resp, rd_resp;
  logic [31:0] rdata, rd_word;
  logic rx_full, rx_empty, tx_full, tx_empty;
  logic wr_exec, ar_hs, tx_push, rx_pop;
  logic unused_bits;
  assign unused_bits = ^{S_AXI_WSTB, S_AXI_WDATA[31:8], S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  assign S_AXI_AWREADY = ~aw_held;
  assign S_AXI_WREADY = ~w_held;
  assign S_AXI_ARREADY = ~rvalid;
  assign S_AXI_BVALID = bvalid;
  assign S_AXI_BRESP = bresp;
  assign S_AXI_RVALID = rvalid;
  assign S_AXI_RRESP = rresp;
  assign S_AXI_RDATA = rdata;
  assign IN_READY = ~rx_full;
  assign OUT_VALID = ~tx_empty;
  assign OUT_DATA = tx_head;
  always_comb begin
    ar_sel = reg_e'(S_AXI_ARADDR[3:2]);
    wr_exec = aw_held & w_held & ~bvalid;
    tx_push = wr_exec & (aw_sel == REG_TX) & ~tx_full;
    wr_resp = (aw_sel == REG_TX && !tx_full) ? RESP_OKAY : RESP_SLVERR;
    ar_hs = S_AXI_ARVALID & ~rvalid;
    rx_pop = ar_hs & (ar_sel == REG_RX) & ~rx_empty;
    rd_resp = (ar_sel == REG_STATUS || (ar_sel == REG_RX && !rx_empty)) ? RESP_OKAY : RESP_SLVERR;
    rd_word = (ar_sel == REG_STATUS) ? status_word(rx_empty, tx_full, tx_empty)
            : (ar_sel == REG_RX && !rx_empty) ? {24'b0, rx_head} : 32'b0;
  end
  // Each latch fills on its own handshake and empties only when the write executes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      aw_held <= 1'b0;
      w_held <= 1'b0;
      aw_sel <= REG_RX;
      w_byte <= '0;
    end else if (wr_exec) begin
      aw_held <= 1'b0;
      w_held <= 1'b0;
    end else begin
      if (S_AXI_AWVALID && !aw_held) begin
        aw_held <= 1'b1;
        aw_sel <= reg_e'(S_AXI_AWADDR[3:2]);
      end
      if (S_AXI_WVALID && !w_held) begin
        w_held <= 1'b1;
        w_byte <= S_AXI_WDATA[7:0];
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      bvalid <= 1'b0;
      bresp <= RESP_OKAY;
    end else if (wr_exec) begin
      bvalid <= 1'b1;
      bresp <= wr_resp;
    end else if (S_AXI_BREADY) begin
      bvalid <= 1'b0;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      rvalid <= 1'b0;
      rresp <= RESP_OKAY;
      rdata <= '0;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      rresp <= rd_resp;
      rdata <= rd_word;
    end else if (S_AXI_RREADY) begin
      rvalid <= 1'b0;
    end
  end
  io_fifo #(.W(8), .DEPTH(DEPTH)) u_rx (
    .clk(CLK), .rst(RST), .push(IN_VALID), .din(IN_DATA), .pop(rx_pop),
    .full(rx_full), .empty(rx_empty), .head(rx_head)
  );
  io_fifo #(.W(8), .DEPTH(DEPTH)) u_tx (
    .clk(CLK), .rst(RST), .push(tx_push), .din(w_byte), .pop(OUT_READY),
    .full(tx_full), .empty(tx_empty), .head(tx_head)
  );
endmodule

// File: tb/tb_io_axil_responder.sv
// tb_io_axil_responder: randomized AXI-Lite/byte-port traffic checked against queue-based model.
module tb_io_axil_responder;
  localparam int DEPTH = 8;
  logic clk = 0, rst = 0;
  logic [3:0] awaddr = 0, araddr = 0, wstb = 0;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0] wdata = 0;
  logic awready, wready, bvalid, arready, rvalid, in_ready, out_valid;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata;
  logic [7:0] in_data = 0, out_data;
  logic in_valid = 0, out_ready = 0;
  int pass_cnt = 0, total_cnt = 0;
  logic [7:0] rx_q[$], tx_q[$];

  io_axil_responder #(.DEPTH(DEPTH)) dut (
    .CLK(clk), .RST(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTB(wstb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(in_ready),
    .OUT_DATA(out_data), .OUT_VALID(out_valid), .OUT_READY(out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_status();
    return {29'b0, tx_q.size() == 0, tx_q.size() == DEPTH, rx_q.size() != 0};
  endfunction

  // Expected response of a write, applied to the model at the moment it would execute.
  function automatic logic [1:0] model_write(input logic [3:0] a, input logic [7:0] d);
    if (a[3:2] != 2'd1 || tx_q.size() == DEPTH) return 2'b10;
    tx_q.push_back(d);
    return 2'b00;
  endfunction

  function automatic logic [33:0] model_read(input logic [3:0] a);
    if (a[3:2] == 2'd2) return {2'b00, model_status()};
    if (a[3:2] == 2'd0 && rx_q.size() != 0) return {2'b00, 24'b0, rx_q.pop_front()};
    return {2'b10, 32'b0};
  endfunction

  task automatic wait_bvalid(input string tag);
    int n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    if (!bvalid) begin
      total_cnt++;
      $display("FAIL %s: BVALID timeout, got 0 need 1", tag);
    end
  endtask

  task automatic wait_rvalid(input string tag);
    int n = 0;
    while (!rvalid && n < 20) begin tick(); n++; end
    if (!rvalid) begin
      total_cnt++;
      $display("FAIL %s: RVALID timeout, got 0 need 1", tag);
    end
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, output logic [1:0] resp);
    int n = 0;
    logic ha, hw;
    awaddr = a; wdata = d; wstb = 4'($urandom); awvalid = 1; wvalid = 1;
    while ((awvalid || wvalid) && n < 20) begin
      ha = awvalid && awready;
      hw = wvalid && wready;
      tick();
      if (ha) awvalid = 0;
      if (hw) wvalid = 0;
      n++;
    end
    awvalid = 0; wvalid = 0;
    wait_bvalid("write");
    resp = bresp;
    bready = 1;
    tick();
    bready = 0;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n = 0;
    araddr = a; arvalid = 1;
    while (!arready && n < 20) begin tick(); n++; end
    tick();
    arvalid = 0;
    wait_rvalid("read");
    d = rdata; resp = rresp;
    rready = 1;
    tick();
    rready = 0;
  endtask

  task automatic push_in(input logic [7:0] b);
    logic rdy;
    in_data = b; in_valid = 1;
    rdy = in_ready;
    total_cnt++;
    if (rdy !== (rx_q.size() < DEPTH)) $display("FAIL in_ready: got %b need %b", rdy, rx_q.size() < DEPTH);
    else pass_cnt++;
    tick();
    in_valid = 0;
    if (rdy && rx_q.size() < DEPTH) rx_q.push_back(b);
  endtask

  task automatic pop_out();
    out_ready = 1;
    total_cnt++;
    if (out_valid !== (tx_q.size() != 0)) $display("FAIL out_valid: got %b need %b", out_valid, tx_q.size() != 0);
    else pass_cnt++;
    if (tx_q.size() != 0) begin
      total_cnt++;
      if (out_data !== tx_q[0]) $display("FAIL out_data: got %h need %h", out_data, tx_q[0]);
      else pass_cnt++;
    end
    tick();
    out_ready = 0;
    if (tx_q.size() != 0) void'(tx_q.pop_front());
  endtask

  task automatic do_reset();
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 0; rready = 0; in_valid = 0; out_ready = 0;
    rst = 1;
    tick(); tick();
    rst = 0;
    rx_q.delete(); tx_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if ({awready, wready, arready, in_ready} !== 4'b1111) $display("FAIL reset_ready: got %b need 1111", {awready, wready, arready, in_ready});
    else pass_cnt++;
    total_cnt++;
    if ({bvalid, rvalid, out_valid} !== 3'b000) $display("FAIL reset_valid: got %b need 000", {bvalid, rvalid, out_valid});
    else pass_cnt++;
    total_cnt++;
    if ({bresp, rresp, rdata} !== 36'b0) $display("FAIL reset_data: got %h need 0", {bresp, rresp, rdata});
    else pass_cnt++;
  endtask

  task automatic test_w_then_aw();
    logic [1:0] exp;
    wdata = 32'hFFFF_FF41; wvalid = 1;
    tick();
    wvalid = 0;
    tick(); tick();
    total_cnt++;
    if (bvalid !== 1'b0) $display("FAIL w_only_bvalid: got %b need 0", bvalid);
    else pass_cnt++;
    awaddr = 4'h4; awvalid = 1;
    tick();
    awvalid = 0;
    exp = model_write(4'h4, 8'h41);
    wait_bvalid("w_then_aw");
    total_cnt++;
    if (bresp !== exp) $display("FAIL w_then_aw_bresp: got %b need %b", bresp, exp);
    else pass_cnt++;
    bready = 1; tick(); bready = 0;
    total_cnt++;
    if ({out_valid, out_data} !== {1'b1, tx_q[0]}) $display("FAIL w_then_aw_out: got %b/%h need 1/%h", out_valid, out_data, tx_q[0]);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++;
      if (bvalid !== 1'b0) $display("FAIL w_then_aw_single_b: got %b need 0", bvalid);
      else pass_cnt++;
    end
    while (tx_q.size() != 0) pop_out();
  endtask

  task automatic test_rx_read();
    logic [31:0] d;
    logic [1:0] r;
    logic [33:0] exp;
    push_in(8'h5A);
    for (int i = 0; i < 2; i++) begin
      exp = model_read(4'h0);
      axi_read(4'h0, d, r);
      total_cnt++;
      if ({r, d} !== exp) $display("FAIL rx_read%0d: got %b/%h need %b/%h", i, r, d, exp[33:32], exp[31:0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_tx_overflow();
    logic [31:0] d;
    logic [1:0] r, exp;
    logic [33:0] exps;
    for (int i = 0; i <= DEPTH; i++) begin
      d = $urandom;
      exp = model_write(4'h4, d[7:0]);
      axi_write(4'h4, d, r);
      total_cnt++;
      if (r !== exp) $display("FAIL tx_fill%0d: got %b need %b", i, r, exp);
      else pass_cnt++;
    end
    exps = model_read(4'h8);
    axi_read(4'h8, d, r);
    total_cnt++;
    if ({r, d} !== exps) $display("FAIL tx_full_status: got %b/%h need %b/%h", r, d, exps[33:32], exps[31:0]);
    else pass_cnt++;
    while (tx_q.size() != 0) pop_out();
  endtask

  task automatic test_bready_stall();
    logic [7:0] d1, d2;
    logic [1:0] e1, e2;
    d1 = 8'($urandom); d2 = 8'($urandom);
    awaddr = 4'h4; wdata = {24'h0, d1}; awvalid = 1; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    e1 = model_write(4'h4, d1);
    wait_bvalid("stall_first");
    wdata = {24'h0, d2}; awvalid = 1; wvalid = 1;
    tick();
    awvalid = 0; wvalid = 0;
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if ({bvalid, awready, wready} !== 3'b100) $display("FAIL stall_cyc%0d: got %b need 100", i, {bvalid, awready, wready});
      else pass_cnt++;
      if (i == 0) pop_out();
      else begin
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL stall_no_second_exec: got %b need 0", out_valid);
        else pass_cnt++;
        tick();
      end
    end
    total_cnt++;
    if (bresp !== e1) $display("FAIL stall_bresp1: got %b need %b", bresp, e1);
    else pass_cnt++;
    bready = 1; tick(); bready = 0;
    e2 = model_write(4'h4, d2);
    wait_bvalid("stall_second");
    total_cnt++;
    if (bresp !== e2) $display("FAIL stall_bresp2: got %b need %b", bresp, e2);
    else pass_cnt++;
    bready = 1; tick(); bready = 0;
    while (tx_q.size() != 0) pop_out();
  endtask

  task automatic test_full_rx_pop();
    logic [33:0] exp;
    while (rx_q.size() < DEPTH) push_in(8'($urandom));
    in_data = 8'($urandom); in_valid = 1;
    araddr = 4'h0; arvalid = 1;
    total_cnt++;
    if ({in_ready, arready} !== 2'b01) $display("FAIL full_rx_ready: got %b need 01", {in_ready, arready});
    else pass_cnt++;
    exp = model_read(4'h0);
    tick();
    in_valid = 0; arvalid = 0;
    total_cnt++;
    if (in_ready !== 1'b1) $display("FAIL full_rx_ready_after: got %b need 1", in_ready);
    else pass_cnt++;
    wait_rvalid("full_rx");
    total_cnt++;
    if ({rresp, rdata} !== exp) $display("FAIL full_rx_data: got %b/%h need %b/%h", rresp, rdata, exp[33:32], exp[31:0]);
    else pass_cnt++;
    rready = 1; tick(); rready = 0;
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [1:0] r, ew;
    logic [33:0] er;
    logic [3:0] a;
    for (int i = 0; i < 300; i++) begin
      a = 4'($urandom);
      d = $urandom;
      case ($urandom_range(0, 3))
        0: push_in(8'($urandom));
        1: begin
          ew = model_write(a, d[7:0]);
          axi_write(a, d, r);
          total_cnt++;
          if (r !== ew) $display("FAIL rand_write %h: got %b need %b", a, r, ew);
          else pass_cnt++;
        end
        2: begin
          er = model_read(a);
          axi_read(a, d, r);
          total_cnt++;
          if ({r, d} !== er) $display("FAIL rand_read %h: got %b/%h need %b/%h", a, r, d, er[33:32], er[31:0]);
          else pass_cnt++;
        end
        default: pop_out();
      endcase
    end
  endtask

  task automatic test_reset_mid();
    logic seen = 0;
    awaddr = 4'h4; awvalid = 1;
    tick();
    awvalid = 0;
    araddr = 4'h8; arvalid = 1;
    tick();
    arvalid = 0;
    total_cnt++;
    if ({rvalid, awready} !== 2'b10) $display("FAIL mid_setup: got %b need 10", {rvalid, awready});
    else pass_cnt++;
    rst = 1;
    tick();
    total_cnt++;
    if ({bvalid, rvalid, out_valid} !== 3'b000) $display("FAIL mid_reset_valids: got %b need 000", {bvalid, rvalid, out_valid});
    else pass_cnt++;
    rst = 0;
    rx_q.delete(); tx_q.delete();
    wdata = 32'h77; wvalid = 1; bready = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      wvalid = 0;
      if (bvalid) seen = 1;
    end
    bready = 0;
    total_cnt++;
    if (seen !== 1'b0) $display("FAIL mid_no_bvalid: got %b need 0", seen);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_w_then_aw();
    test_rx_read();
    test_tx_overflow();
    test_bready_stall();
    test_full_rx_pop();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
